// File: rtl/demux16_reg.sv
// Registered 1-to-16 demultiplexer with a one-entry valid/ready holding register per channel.
// Optional stall counter port stall_cnt is compiled in with `define DEMUX16_STATS_EN.
module demux16_reg #(
  parameter int WIDTH = 16,
  parameter int NCH   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           sel,
  input  logic                 mode,
  output logic [3:0]           cur_ch,
  output logic [NCH*WIDTH-1:0] out_data,
  output logic [NCH-1:0]       out_valid,
  input  logic [NCH-1:0]       out_ready
`ifdef DEMUX16_STATS_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  // Handshake: a word moves on a channel or input port only in a cycle where
  // valid and ready are both high at the rising edge; ready never depends on valid.

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_t;

  ch_state_t              ch_state     [NCH];
  ch_state_t              ch_state_nxt [NCH];
  logic [3:0]             rr_ptr;
  logic                   accept;
  logic [NCH-1:0]         load;
  logic [NCH*WIDTH-1:0]   data_q;

  // While in reset cur_ch follows sel regardless of mode.
  always_comb begin
    cur_ch   = (!rst_n || !mode) ? sel : rr_ptr;
    in_ready = !out_valid[cur_ch] || out_ready[cur_ch];
    accept   = in_valid && in_ready;
  end

  always_comb begin
    load = '0;
    for (int k = 0; k < NCH; k++) begin
      load[k] = accept && (cur_ch == 4'(k));
    end
  end

  // Per-channel EMPTY/FULL next-state; out_valid is the state itself.
  always_comb begin
    out_valid = '0;
    for (int k = 0; k < NCH; k++) begin
      ch_state_nxt[k] = ch_state[k];
      out_valid[k]    = (ch_state[k] == CH_FULL);
      case (ch_state[k])
        CH_EMPTY: if (load[k]) ch_state_nxt[k] = CH_FULL;
        CH_FULL:  if (out_ready[k] && !load[k]) ch_state_nxt[k] = CH_EMPTY;
        default:  ch_state_nxt[k] = CH_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) ch_state[k] <= CH_EMPTY;
    end else begin
      for (int k = 0; k < NCH; k++) ch_state[k] <= ch_state_nxt[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (load[k]) data_q[k*WIDTH +: WIDTH] <= in_data;
      end
    end
  end

  assign out_data = data_q;

  // The pointer only advances on round-robin accepts, so explicit mode leaves it parked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 4'd0;
    end else if (accept && mode) begin
      rr_ptr <= rr_ptr + 4'd1;
    end
  end

`ifdef DEMUX16_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= 16'd0;
    end else if (in_valid && !in_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_demux16_reg.sv
// Directed, table-driven bench for demux16_reg; stall counter checks run when
// DEMUX16_STATS_EN is defined.
module tb_demux16_reg;

  localparam int W   = 16;
  localparam int NCH = 16;

  logic             clk;
  logic             rst_n;
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       sel;
  logic             mode;
  logic [3:0]       cur_ch;
  logic [NCH*W-1:0] out_data;
  logic [NCH-1:0]   out_valid;
  logic [NCH-1:0]   out_ready;
`ifdef DEMUX16_STATS_EN
  logic [15:0]      stall_cnt;
`endif

  demux16_reg #(.WIDTH(W), .NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .mode      (mode),
    .cur_ch    (cur_ch),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX16_STATS_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic           mode;
    logic [3:0]     sel;
    logic           vld;
    logic [W-1:0]   data;
    logic [NCH-1:0] ordy;
    logic           exp_rdy;
    logic [3:0]     exp_cur;
    logic [NCH-1:0] exp_ov;
    logic [3:0]     exp_ch;
    logic [W-1:0]   exp_dat;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic m, logic [3:0] s, logic v, logic [W-1:0] d,
                              logic [NCH-1:0] r, logic er, logic [3:0] ec,
                              logic [NCH-1:0] eov, logic [3:0] ech, logic [W-1:0] ed);
    vec_t t;
    t.mode = m; t.sel = s; t.vld = v; t.data = d; t.ordy = r;
    t.exp_rdy = er; t.exp_cur = ec; t.exp_ov = eov; t.exp_ch = ech; t.exp_dat = ed;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Driver: called at posedge+1; checks combinational outputs, then registered ones.
  task automatic apply(input vec_t v, input string tag);
    mode = v.mode; sel = v.sel; in_valid = v.vld; in_data = v.data; out_ready = v.ordy;
    #1;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.exp_rdy));
    chk({tag, ".cur_ch"},   32'(cur_ch),   32'(v.exp_cur));
    @(posedge clk); #1;
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v.exp_ov));
    chk({tag, ".slice"}, 32'(out_data[v.exp_ch*W +: W]), 32'(v.exp_dat));
  endtask

  initial begin
    // Explicit sweep: each channel loaded once, previous one drains.
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(1'b0, 4'(k), 1'b1, 16'(k + 1), 16'hFFFF,
                        1'b1, 4'(k), 16'(1) << k, 4'(k), 16'(k + 1)));
    // A 17th explicit accept: rr_ptr must still be parked at 0 afterwards.
    vecs.push_back(mk(1'b0, 4'd3, 1'b1, 16'h0033, 16'hFFFF, 1'b1, 4'd3, 16'h0008, 4'd3, 16'h0033));
    // Round-robin wrap: 17 words land on 0..15 then 0.
    for (int i = 0; i < 17; i++)
      vecs.push_back(mk(1'b1, 4'd9, 1'b1, 16'hA000 + 16'(i), 16'hFFFF,
                        1'b1, 4'(i % 16), 16'(1) << (i % 16), 4'(i % 16), 16'hA000 + 16'(i)));
    // Idle: pointer sits at 1, channel 0 drained but keeps A010, in_data ignored.
    vecs.push_back(mk(1'b1, 4'd9, 1'b0, 16'hDEAD, 16'hFFFF, 1'b1, 4'd1, 16'h0000, 4'd0, 16'hA010));
    // Backpressure on channel 5 then reload.
    vecs.push_back(mk(1'b0, 4'd5, 1'b1, 16'h1234, 16'hFFDF, 1'b1, 4'd5, 16'h0020, 4'd5, 16'h1234));
    vecs.push_back(mk(1'b0, 4'd5, 1'b1, 16'h5678, 16'hFFDF, 1'b0, 4'd5, 16'h0020, 4'd5, 16'h1234));
    vecs.push_back(mk(1'b0, 4'd5, 1'b1, 16'h5678, 16'hFFDF, 1'b0, 4'd5, 16'h0020, 4'd5, 16'h1234));
    vecs.push_back(mk(1'b0, 4'd5, 1'b1, 16'h5678, 16'hFFFF, 1'b1, 4'd5, 16'h0020, 4'd5, 16'h5678));
    vecs.push_back(mk(1'b0, 4'd5, 1'b0, 16'h9999, 16'hFFFF, 1'b1, 4'd5, 16'h0000, 4'd5, 16'h5678));

    // Reset state, asserted from time 0.
    rst_n = 1'b0; mode = 1'b0; sel = 4'd6; in_valid = 1'b0; in_data = '0; out_ready = '0;
    #3;
    chk("rst.out_valid", 32'(out_valid), 32'h0);
    chk("rst.out_data_zero", 32'(out_data == '0), 32'h1);
    chk("rst.cur_ch", 32'(cur_ch), 32'd6);
    chk("rst.in_ready", 32'(in_ready), 32'h1);
    #9;
    rst_n = 1'b1; mode = 1'b1;
    #1;
    chk("rst.rr_cur_ch", 32'(cur_ch), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("vec%0d", i));

    // Mid-operation reset: pointer is at 1, so four words fill channels 1..4.
    for (int i = 0; i < 4; i++)
      apply(mk(1'b1, 4'd0, 1'b1, 16'hC000 + 16'(i), 16'h0000, 1'b1, 4'(i + 1),
               16'(((32'h1 << (i + 2)) - 1) & 32'hFFFE), 4'(i + 1), 16'hC000 + 16'(i)),
            $sformatf("fill%0d", i));
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 32'h0);
    chk("midrst.out_data_zero", 32'(out_data == '0), 32'h1);
    mode = 1'b0; sel = 4'd9;
    #1;
    chk("midrst.cur_ch_sel", 32'(cur_ch), 32'd9);
    @(posedge clk); #3;
    rst_n = 1'b1; mode = 1'b1; in_valid = 1'b0;
    #1;
    chk("midrst.rr_ptr", 32'(cur_ch), 32'd0);
    @(posedge clk); #1;
    apply(mk(1'b1, 4'd7, 1'b1, 16'hBEEF, 16'h0000, 1'b1, 4'd0, 16'h0001, 4'd0, 16'hBEEF), "post_rst");

`ifdef DEMUX16_STATS_EN
    chk("stats.after_reset", 32'(stall_cnt), 32'd0);
    apply(mk(1'b0, 4'd2, 1'b1, 16'h2222, 16'h0000, 1'b1, 4'd2, 16'h0005, 4'd2, 16'h2222), "stats_fill");
    // in_valid stays high with channel 2 full: every edge from here is a stall.
    repeat (10) @(posedge clk);
    #1;
    chk("stats.ten", 32'(stall_cnt), 32'd10);
    repeat (70000) @(posedge clk);
    #1;
    chk("stats.saturate", 32'(stall_cnt), 32'h0000FFFF);
    in_valid = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
